fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I core. Owns the program counter, drives the fetch address into the combinational word-addressed instruction memory, and captures the returned word plus its PC into the Decode-side register. Honors hazard-unit stall/flush and Execute-stage branch/jump redirects, and flags misaligned redirect targets.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in InstrD on reset/flush

Ports:
- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID register
- FlushD  in  1  replace IF/ID contents with bubble
- PCSrcE  in  1  redirect request from Execute
- PCTargetE  in  32  redirect target from Execute
- RDF  in  32  instruction word from instruction memory for address PCF
- PCF  out  32  fetch address to instruction memory (word-aligned)
- InstrD  out  32  instruction in Decode
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD + 4
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble)
- MisalignD  out  1  InstrD was fetched from a redirect whose target had PCTargetE[1:0] != 0
- FetchCount  out  32  number of valid instructions written into IF/ID

## Operation
- Reset (rst_n low, asynchronous): PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, MisalignD=0, internal MisalignF=0, FetchCount=0.
- PCPlus4F = PCF + 4, 32-bit modulo (0xFFFF_FFFC wraps to 0x0000_0000).
- PC update per edge, priority order:
  - PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}; MisalignF <= |PCTargetE[1:0]. Redirect wins over StallF.
  - else StallF=1: PCF and MisalignF hold.
  - else: PCF <= PCPlus4F; MisalignF <= 0.
- IF/ID update per edge, priority order:
  - FlushD=1: InstrD=NOP_INSTR, ValidD=0, MisalignD=0, PCD=0, PCPlus4D=0. Flush wins over StallD.
  - else StallD=1: all IF/ID outputs hold.
  - else: InstrD<=RDF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1, MisalignD<=MisalignF.
- FetchCount increments (mod 2^32) on every edge where the "else" capture branch is taken; holds otherwise.
- Block performs no decoding; MisalignD is informational, consumed by the trap logic downstream.
- No internal state besides PCF, MisalignF, IF/ID fields, FetchCount.

## Timing
- PCF registered; instruction memory read is combinational, so RDF is valid in the same cycle as PCF.
- Fetch-to-Decode latency: 1 cycle (word for PCF in cycle n appears on InstrD in cycle n+1).
- First edge after rst_n rises captures the word at RESET_PC; PCF advances to RESET_PC+4 on that edge.
- Redirect: PCSrcE sampled high at edge n → PCF=target during cycle n+1, its instruction on InstrD in cycle n+2. Hazard unit asserts FlushD with PCSrcE; the wrong-path word fetched in cycle n is discarded.
- Stall: StallF=StallD=1 for k cycles → PCF and InstrD frozen for k cycles, no fetch lost or duplicated.
- Asynchronous reset mid-operation: all outputs go to reset values immediately, without waiting for a clock edge; removal is synchronous to the design via the reset synchronizer outside this block.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset + sequential fetch: memory word i = 0x1000_0000+i; release rst_n → InstrD sequence 0x1000_0000, 0x1000_0001, … with PCD 0,4,8, ValidD=1, FetchCount counts 1,2,3.
- Stall: assert StallF=StallD=1 for 3 cycles at PCF=0x10 → PCF stays 0x10, InstrD holds word of 0xC, FetchCount unchanged; release → 0x10 word next, no skip/duplicate.
- Redirect + flush: PCSrcE=1, FlushD=1, PCTargetE=0x40 while PCF=0x18 → next cycle PCF=0x40, InstrD=0x0000_0013, ValidD=0; following cycle InstrD=word(0x40), PCD=0x40.
- Misaligned redirect: PCTargetE=0x42 → PCF=0x40, MisalignD=1 with that instruction only; next sequential instruction MisalignD=0.
- Priority: PCSrcE=1 with StallF=1 → PCF takes target; FlushD=1 with StallD=1 → bubble.
- Wrap and async reset: RESET_PC=0xFFFF_FFFC → second fetch at 0x0; drop rst_n between edges mid-stream → PCF=RESET_PC, ValidD=0, FetchCount=0 immediately.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the 5-stage RV32I core.
// Owns the PC, handles redirects/stalls/flushes and tags words fetched from misaligned redirect targets.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] RDF,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignD,
  output logic [31:0] FetchCount
);

  logic        MisalignF;
  logic [31:0] PCPlus4F;

  assign PCPlus4F = PCF + 32'd4;

  // A redirect beats a fetch stall so a taken branch is never lost while the front end is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PCF       <= RESET_PC;
      MisalignF <= 1'b0;
    end else if (PCSrcE) begin
      PCF       <= {PCTargetE[31:2], 2'b00};
      MisalignF <= |PCTargetE[1:0];
    end else if (!StallF) begin
      PCF       <= PCPlus4F;
      MisalignF <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD     <= NOP_INSTR;
      PCD        <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
      MisalignD  <= 1'b0;
      FetchCount <= 32'd0;
    end else if (FlushD) begin
      InstrD     <= NOP_INSTR;
      PCD        <= 32'd0;
      PCPlus4D   <= 32'd0;
      ValidD     <= 1'b0;
      MisalignD  <= 1'b0;
    end else if (!StallD) begin
      InstrD     <= RDF;
      PCD        <= PCF;
      PCPlus4D   <= PCPlus4F;
      ValidD     <= 1'b1;
      MisalignD  <= MisalignF;
      FetchCount <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized hazard traffic
// compared every cycle against a behavioural model of the fetch pipeline.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] RDF, PCF, InstrD, PCD, PCPlus4D, FetchCount;
  logic        ValidD, MisalignD;

  logic [31:0] rdf_w, pcf_w, instr_w, pcd_w, pcp4_w, count_w;
  logic        valid_w, mis_w;

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Model state: the architectural view of the fetch pipeline.
  logic [31:0] m_pcf, m_instr, m_pcd, m_pcp4, m_count;
  logic        m_misf, m_valid, m_mis;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  assign RDF   = mem_word(PCF);
  assign rdf_w = mem_word(pcf_w);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RDF(RDF), .PCF(PCF), .InstrD(InstrD),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .MisalignD(MisalignD),
    .FetchCount(FetchCount)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .StallF(1'b0), .StallD(1'b0), .FlushD(1'b0),
    .PCSrcE(1'b0), .PCTargetE(32'd0), .RDF(rdf_w), .PCF(pcf_w), .InstrD(instr_w),
    .PCD(pcd_w), .PCPlus4D(pcp4_w), .ValidD(valid_w), .MisalignD(mis_w),
    .FetchCount(count_w)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcf = 32'd0; m_misf = 1'b0; m_instr = NOP; m_pcd = 32'd0;
    m_pcp4 = 32'd0; m_valid = 1'b0; m_mis = 1'b0; m_count = 32'd0;
  endtask

  // Drives one cycle of hazard inputs and advances the model across the coming edge.
  task automatic apply_stimulus(input bit sf, input bit sd, input bit fl, input bit ps,
                                input logic [31:0] tgt);
    logic [31:0] n_pcf, n_instr, n_pcd, n_pcp4, n_count;
    logic        n_misf, n_valid, n_mis;
    StallF = sf; StallD = sd; FlushD = fl; PCSrcE = ps; PCTargetE = tgt;
    n_pcf = m_pcf; n_misf = m_misf;
    if (ps) begin
      n_pcf = tgt & 32'hFFFF_FFFC;
      n_misf = (tgt % 4) != 0;
    end else if (!sf) begin
      n_pcf = m_pcf + 32'd4;
      n_misf = 1'b0;
    end
    n_instr = m_instr; n_pcd = m_pcd; n_pcp4 = m_pcp4;
    n_valid = m_valid; n_mis = m_mis; n_count = m_count;
    if (fl) begin
      n_instr = NOP; n_pcd = 0; n_pcp4 = 0; n_valid = 0; n_mis = 0;
    end else if (!sd) begin
      n_instr = mem_word(m_pcf); n_pcd = m_pcf; n_pcp4 = m_pcf + 32'd4;
      n_valid = 1; n_mis = m_misf; n_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
    m_pcf = n_pcf; m_misf = n_misf; m_instr = n_instr; m_pcd = n_pcd;
    m_pcp4 = n_pcp4; m_valid = n_valid; m_mis = n_mis; m_count = n_count;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("PCF", PCF, m_pcf);
      check_output("InstrD", InstrD, m_instr);
      check_output("PCD", PCD, m_pcd);
      check_output("PCPlus4D", PCPlus4D, m_pcp4);
      check_output("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
      check_output("MisalignD", {31'd0, MisalignD}, {31'd0, m_mis});
      check_output("FetchCount", FetchCount, m_count);
    end
  end

  initial begin
    rst_n = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0;
    model_reset();
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("wrap_reset_pc", pcf_w, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Sequential fetch from reset.
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("first_instr", InstrD, 32'h1000_0000);
    check_output("first_count", FetchCount, 32'd1);
    check_output("wrap_pcf", pcf_w, 32'h0000_0000);
    check_output("wrap_pcd", pcd_w, 32'hFFFF_FFFC);
    check_output("wrap_pcp4", pcp4_w, 32'h0000_0000);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("wrap_second_pcd", pcd_w, 32'h0000_0000);
    check_output("wrap_second_instr", instr_w, 32'h1000_0000);
    repeat (2) apply_stimulus(0, 0, 0, 0, 0);
    check_output("seq_pcf", PCF, 32'h10);

    // Three-cycle stall at PCF=0x10.
    repeat (3) apply_stimulus(1, 1, 0, 0, 0);
    check_output("stall_pcf", PCF, 32'h10);
    check_output("stall_instr", InstrD, 32'h1000_0003);
    check_output("stall_count", FetchCount, 32'd4);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("unstall_instr", InstrD, 32'h1000_0004);
    apply_stimulus(0, 0, 0, 0, 0);

    // Redirect with flush while PCF=0x18.
    apply_stimulus(0, 0, 1, 1, 32'h40);
    check_output("redir_pcf", PCF, 32'h40);
    check_output("redir_bubble", InstrD, NOP);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("redir_instr", InstrD, 32'h1000_0010);
    check_output("redir_pcd", PCD, 32'h40);

    // Misaligned redirect tags only the target instruction.
    apply_stimulus(0, 0, 1, 1, 32'h42);
    check_output("mis_pcf", PCF, 32'h40);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("mis_tagged", {31'd0, MisalignD}, 32'd1);
    apply_stimulus(0, 0, 0, 0, 0);
    check_output("mis_cleared", {31'd0, MisalignD}, 32'd0);

    // Redirect beats StallF; flush beats StallD.
    apply_stimulus(1, 1, 1, 1, 32'h100);
    check_output("prio_pcf", PCF, 32'h100);
    check_output("prio_valid", {31'd0, ValidD}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom);
    end

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    check_output("async_pcf", PCF, 32'h0);
    check_output("async_valid", {31'd0, ValidD}, 32'd0);
    check_output("async_count", FetchCount, 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      apply_stimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom);
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
